// File: rtl/sap_pkg.sv
// Shared encodings for the SAP micro-step sequencer: opcodes, step values and
// control-word bit positions used by both the decoder and the top-level wiring.
package sap_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned STEP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h7;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_e;

    // CW_HALT is internal: it requests the halted bit and never leaves the block.
    localparam int unsigned CW_PC_OUT    = 0;
    localparam int unsigned CW_PC_INC    = 1;
    localparam int unsigned CW_PC_LOAD   = 2;
    localparam int unsigned CW_MAR_WRITE = 3;
    localparam int unsigned CW_MEM_OUT   = 4;
    localparam int unsigned CW_MEM_WRITE = 5;
    localparam int unsigned CW_IR_WRITE  = 6;
    localparam int unsigned CW_IR_OUT    = 7;
    localparam int unsigned CW_A_WRITE   = 8;
    localparam int unsigned CW_A_OUT     = 9;
    localparam int unsigned CW_B_WRITE   = 10;
    localparam int unsigned CW_ALU_OUT   = 11;
    localparam int unsigned CW_ALU_SUB   = 12;
    localparam int unsigned CW_OUT_WRITE = 13;
    localparam int unsigned CW_HALT      = 14;
    localparam int unsigned CW_W         = 15;

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the sequencer and the SAP datapath: run/opcode/flag
// in, per-function strobes and debug state out.
interface sap_control_sequencer_if;
    import sap_pkg::*;

    logic              run;
    logic [OP_W-1:0]   ir_opcode;
    logic              zero_flag;
    logic              pc_out;
    logic              pc_inc;
    logic              pc_load;
    logic              mar_write;
    logic              mem_out;
    logic              mem_write;
    logic              ir_write;
    logic              ir_out;
    logic              a_write;
    logic              a_out;
    logic              b_write;
    logic              alu_out;
    logic              alu_sub;
    logic              out_write;
    logic              halted;
    logic [STEP_W-1:0] step;

    modport master (
        input  run, ir_opcode, zero_flag,
        output pc_out, pc_inc, pc_load, mar_write, mem_out, mem_write,
               ir_write, ir_out, a_write, a_out, b_write, alu_out, alu_sub,
               out_write, halted, step
    );

    modport slave (
        output run, ir_opcode, zero_flag,
        input  pc_out, pc_inc, pc_load, mar_write, mem_out, mem_write,
               ir_write, ir_out, a_write, a_out, b_write, alu_out, alu_sub,
               out_write, halted, step
    );

endinterface

// File: rtl/sap_control_decode.sv
// Pure decode of (step, opcode, zero_flag) into the raw control word and the
// flag marking the final micro-step of the current instruction.
module sap_control_decode
    import sap_pkg::*;
(
    input  step_e             step,
    input  logic [OP_W-1:0]   opcode,
    input  logic              zero_flag,
    output logic [CW_W-1:0]   cw,
    output logic              last_step
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                cw[CW_PC_OUT]    = 1'b1;
                cw[CW_MAR_WRITE] = 1'b1;
            end
            T1: begin
                cw[CW_MEM_OUT]  = 1'b1;
                cw[CW_IR_WRITE] = 1'b1;
                cw[CW_PC_INC]   = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT]    = 1'b1;
                        cw[CW_MAR_WRITE] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_A_WRITE] = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT]  = zero_flag;
                        cw[CW_PC_LOAD] = zero_flag;
                        last_step      = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]     = 1'b1;
                        cw[CW_OUT_WRITE] = 1'b1;
                        last_step        = 1'b1;
                    end
                    OP_HLT: begin
                        cw[CW_HALT] = 1'b1;
                        last_step   = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_MEM_OUT] = 1'b1;
                        cw[CW_A_WRITE] = 1'b1;
                        last_step      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_MEM_OUT] = 1'b1;
                        cw[CW_B_WRITE] = 1'b1;
                        cw[CW_ALU_SUB] = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]     = 1'b1;
                        cw[CW_MEM_WRITE] = 1'b1;
                        last_step        = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_WRITE] = 1'b1;
                    cw[CW_ALU_SUB] = (opcode == OP_SUB);
                end
                last_step = 1'b1;
            end
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP micro-step sequencer: step counter and sticky halt, with run/reset/halt
// gating applied to the decoded strobes.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned NSTEP = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    sap_control_sequencer_if.master     bus
);

    step_e            step_q, step_d;
    logic             halted_q, halted_d;
    logic [CW_W-1:0]  cw_raw;
    logic [CW_W-1:0]  cw_c;
    logic             last_step;
    logic             active_c;

    sap_control_decode u_decode (
        .step      (step_q),
        .opcode    (bus.ir_opcode),
        .zero_flag (bus.zero_flag),
        .cw        (cw_raw),
        .last_step (last_step)
    );

    assign active_c = ~rst & bus.run & ~halted_q;
    assign cw_c     = active_c ? cw_raw : '0;

    // Advance while active; a frozen step resumes exactly where it stopped.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (active_c) begin
            if (last_step || (3'(step_q) >= 3'(NSTEP - 1))) begin
                step_d = T0;
            end else begin
                step_d = step_e'(3'(step_q) + 3'd1);
            end
            if (cw_raw[CW_HALT]) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign bus.pc_out    = cw_c[CW_PC_OUT];
    assign bus.pc_inc    = cw_c[CW_PC_INC];
    assign bus.pc_load   = cw_c[CW_PC_LOAD];
    assign bus.mar_write = cw_c[CW_MAR_WRITE];
    assign bus.mem_out   = cw_c[CW_MEM_OUT];
    assign bus.mem_write = cw_c[CW_MEM_WRITE];
    assign bus.ir_write  = cw_c[CW_IR_WRITE];
    assign bus.ir_out    = cw_c[CW_IR_OUT];
    assign bus.a_write   = cw_c[CW_A_WRITE];
    assign bus.a_out     = cw_c[CW_A_OUT];
    assign bus.b_write   = cw_c[CW_B_WRITE];
    assign bus.alu_out   = cw_c[CW_ALU_OUT];
    assign bus.alu_sub   = cw_c[CW_ALU_SUB];
    assign bus.out_write = cw_c[CW_OUT_WRITE];
    assign bus.halted    = halted_q;
    assign bus.step      = 3'(step_q);

    // Shared 16-bit bus: never more than one driver per step.
    a_one_bus_driver: assert property (@(posedge clk)
        $onehot0({cw_c[CW_PC_OUT], cw_c[CW_MEM_OUT], cw_c[CW_IR_OUT],
                  cw_c[CW_A_OUT], cw_c[CW_ALU_OUT]}));

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for the SAP sequencer: fetch, each opcode's strobe pattern and
// latency, pause/resume, sticky halt, and a randomized bus-driver sweep.
module tb_sap_control_sequencer;

    logic clk = 1'b0;
    logic rst;

    sap_control_sequencer_if bus ();

    sap_control_sequencer #(.NSTEP(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] S_PC_OUT    = 14'h2000;
    localparam logic [13:0] S_PC_INC    = 14'h1000;
    localparam logic [13:0] S_PC_LOAD   = 14'h0800;
    localparam logic [13:0] S_MAR_WRITE = 14'h0400;
    localparam logic [13:0] S_MEM_OUT   = 14'h0200;
    localparam logic [13:0] S_MEM_WRITE = 14'h0100;
    localparam logic [13:0] S_IR_WRITE  = 14'h0080;
    localparam logic [13:0] S_IR_OUT    = 14'h0040;
    localparam logic [13:0] S_A_WRITE   = 14'h0020;
    localparam logic [13:0] S_A_OUT     = 14'h0010;
    localparam logic [13:0] S_B_WRITE   = 14'h0008;
    localparam logic [13:0] S_ALU_OUT   = 14'h0004;
    localparam logic [13:0] S_ALU_SUB   = 14'h0002;
    localparam logic [13:0] S_OUT_WRITE = 14'h0001;
    localparam logic [13:0] S_NONE      = 14'h0000;
    localparam logic [13:0] S_FETCH0    = S_PC_OUT | S_MAR_WRITE;
    localparam logic [13:0] S_FETCH1    = S_MEM_OUT | S_IR_WRITE | S_PC_INC;
    localparam logic [13:0] S_ADDR      = S_IR_OUT | S_MAR_WRITE;

    logic [13:0] strb;
    logic [4:0]  drivers;
    assign strb = {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_write,
                   bus.mem_out, bus.mem_write, bus.ir_write, bus.ir_out,
                   bus.a_write, bus.a_out, bus.b_write, bus.alu_out,
                   bus.alu_sub, bus.out_write};
    assign drivers = {bus.pc_out, bus.mem_out, bus.ir_out, bus.a_out, bus.alu_out};

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    // Runs one instruction from T0; the opcode is scrambled during fetch to
    // show only the T2-onward value is decoded.
    task automatic do_instr(input string tag, input logic [3:0] op, input logic zf,
                            input logic [13:0] e2, input logic [13:0] e3,
                            input logic [13:0] e4, input int n);
        bus.ir_opcode = ~op;
        bus.zero_flag = zf;
        #1;
        chk({tag, "_t0_step"}, 32'(bus.step), 32'd0);
        chk({tag, "_t0"}, 32'(strb), 32'(S_FETCH0));
        tick();
        chk({tag, "_t1"}, 32'(strb), 32'(S_FETCH1));
        tick();
        bus.ir_opcode = op;
        #1;
        chk({tag, "_t2_step"}, 32'(bus.step), 32'd2);
        chk({tag, "_t2"}, 32'(strb), 32'(e2));
        if (n > 3) begin
            tick();
            chk({tag, "_t3"}, 32'(strb), 32'(e3));
        end
        if (n > 4) begin
            tick();
            chk({tag, "_t4"}, 32'(strb), 32'(e4));
        end
        tick();
        chk({tag, "_end_step"}, 32'(bus.step), 32'd0);
        chk({tag, "_halted"}, 32'(bus.halted), 32'(op == 4'hF));
    endtask

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.ir_opcode = 4'h0;
        bus.zero_flag = 1'b0;
        tick();
        chk("rst_step", 32'(bus.step), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        bus.run = 1'b1;
        #1;
        chk("rst_strobes", 32'(strb), 32'(S_NONE));
        tick();
        chk("rst_strobes2", 32'(strb), 32'(S_NONE));

        // Reset release and fetch into a NOP.
        rst = 1'b0;
        #1;
        chk("fetch_step0", 32'(bus.step), 32'd0);
        chk("fetch_t0", 32'(strb), 32'(S_FETCH0));
        tick();
        chk("fetch_step1", 32'(bus.step), 32'd1);
        chk("fetch_t1", 32'(strb), 32'(S_FETCH1));
        tick();
        chk("fetch_step2", 32'(bus.step), 32'd2);
        chk("fetch_nop_t2", 32'(strb), 32'(S_NONE));
        tick();
        chk("fetch_wrap", 32'(bus.step), 32'd0);

        do_instr("add", 4'h2, 1'b0, S_ADDR, S_MEM_OUT | S_B_WRITE, S_ALU_OUT | S_A_WRITE, 5);
        do_instr("sub", 4'h3, 1'b0, S_ADDR, S_MEM_OUT | S_B_WRITE | S_ALU_SUB,
                 S_ALU_OUT | S_A_WRITE | S_ALU_SUB, 5);
        do_instr("lda", 4'h1, 1'b0, S_ADDR, S_MEM_OUT | S_A_WRITE, S_NONE, 4);
        do_instr("sta", 4'h4, 1'b1, S_ADDR, S_A_OUT | S_MEM_WRITE, S_NONE, 4);
        do_instr("ldi", 4'h5, 1'b0, S_IR_OUT | S_A_WRITE, S_NONE, S_NONE, 3);
        do_instr("jmp", 4'h6, 1'b0, S_IR_OUT | S_PC_LOAD, S_NONE, S_NONE, 3);
        do_instr("jz0", 4'h7, 1'b0, S_NONE, S_NONE, S_NONE, 3);
        do_instr("jz1", 4'h7, 1'b1, S_IR_OUT | S_PC_LOAD, S_NONE, S_NONE, 3);
        do_instr("out", 4'hE, 1'b0, S_A_OUT | S_OUT_WRITE, S_NONE, S_NONE, 3);
        do_instr("nop", 4'h0, 1'b1, S_NONE, S_NONE, S_NONE, 3);
        for (int op = 8; op <= 13; op++) begin
            do_instr($sformatf("undef%0h", op), 4'(op), 1'b1, S_NONE, S_NONE, S_NONE, 3);
        end

        // Pause at T3 of LDA, then resume.
        bus.ir_opcode = 4'h1;
        bus.zero_flag = 1'b0;
        tick();
        tick();
        tick();
        chk("pause_at_t3", 32'(bus.step), 32'd3);
        bus.run = 1'b0;
        #1;
        chk("pause_strobes", 32'(strb), 32'(S_NONE));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("pause_step%0d", i), 32'(bus.step), 32'd3);
            chk($sformatf("pause_zero%0d", i), 32'(strb), 32'(S_NONE));
        end
        bus.run = 1'b1;
        #1;
        chk("resume_t3", 32'(strb), 32'(S_MEM_OUT | S_A_WRITE));
        tick();
        chk("resume_end", 32'(bus.step), 32'd0);

        // Halt is sticky regardless of run until reset.
        do_instr("hlt", 4'hF, 1'b0, S_NONE, S_NONE, S_NONE, 3);
        for (int i = 0; i < 12; i++) begin
            bus.run = i[0];
            #1;
            chk($sformatf("halt_zero%0d", i), 32'(strb), 32'(S_NONE));
            tick();
            chk($sformatf("halt_sticky%0d", i), 32'(bus.halted), 32'd1);
            chk($sformatf("halt_step%0d", i), 32'(bus.step), 32'd0);
        end
        bus.run = 1'b1;
        rst     = 1'b1;
        tick();
        chk("halt_rst_clear", 32'(bus.halted), 32'd0);
        chk("halt_rst_strobes", 32'(strb), 32'(S_NONE));
        rst = 1'b0;
        #1;
        chk("halt_restart_t0", 32'(strb), 32'(S_FETCH0));
        tick();
        tick();
        bus.ir_opcode = 4'h0;
        tick();
        chk("halt_restart_wrap", 32'(bus.step), 32'd0);

        // Random opcode sweep: single bus driver and correct latency.
        for (int i = 0; i < 500; i++) begin
            logic [3:0] op;
            int cyc;
            op = 4'($urandom_range(0, 14));
            bus.ir_opcode = op;
            bus.zero_flag = 1'($urandom);
            #1;
            cyc = 0;
            do begin
                chk($sformatf("rnd%0d_bus", i), 32'($onehot0(drivers)), 32'd1);
                cyc++;
                tick();
            end while (bus.step != 3'd0 && cyc < 8);
            chk($sformatf("rnd%0d_lat_op%0h", i, op), 32'(cyc), 32'(exp_latency(op)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
